// File: rtl/coreUtils.sv
// Shared types for the decode/execute boundary: ALU op codes, RV32I major
// opcodes and the ID/EX control bundle.
package coreUtils;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegW  = 5;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluOr   = 4'd6,
    AluAnd  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9,
    AluNop  = 4'd15
  } alu_codes_t;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpOp     = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic             valid;
    logic [DataW-1:0] pc;
    logic [RegW-1:0]  rs1;
    logic [RegW-1:0]  rs2;
    logic [RegW-1:0]  rd;
    logic [DataW-1:0] imm;
    alu_codes_t       alu_code;
    logic             aluin1_m;
    logic             aluin2_m;
    logic             alu_pc_m;
    logic             alu_imm_m;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             branch;
    logic [2:0]       funct3;
  } id_ex_t;

  // funct3 -> ALU op; alt selects SUB/SRA (instr[30]).
  function automatic alu_codes_t alu_op(input logic [2:0] f3, input logic alt);
    alu_codes_t code;
    unique case (f3)
      3'b000:  code = alt ? AluSub : AluAdd;
      3'b001:  code = AluSll;
      3'b010:  code = AluSlt;
      3'b011:  code = AluSltu;
      3'b100:  code = AluXor;
      3'b101:  code = alt ? AluSra : AluSrl;
      3'b110:  code = AluOr;
      default: code = AluAnd;
    endcase
    return code;
  endfunction

  // Empty ID/EX slot: not valid, NOP, every control bit low.
  function automatic id_ex_t bubble_bundle(input logic [DataW-1:0] pc);
    id_ex_t b;
    b          = '0;
    b.pc       = pc;
    b.alu_code = AluNop;
    return b;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the opcode
// and sign-extends it. Purely combinational.
module imm_gen
  import coreUtils::*;
(
  input  logic [DataW-1:0] i_instr,
  output logic [DataW-1:0] o_imm
);

  opcode_t w_opcode;
  assign w_opcode = opcode_t'(i_instr[6:0]);

  // Format select; R-type and unknown opcodes carry no immediate.
  always_comb begin
    o_imm = '0;
    case (w_opcode)
      OpImm, OpLoad, OpJalr: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OpStore:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OpBranch: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
      OpLui, OpAuipc: o_imm = {i_instr[31:12], 12'b0};
      OpJal:    o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
      default:  o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per valid/ready handshake into
// the execute control bundle held in the ID/EX register, with load-use
// interlock and flush-to-bubble.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal encodings are captured with
// ex_illegal=1 and the stage halts until reset. Without it they become bubbles.
module decode_stage
  import coreUtils::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_imm,
  output alu_codes_t       ex_aluCode,
  output logic             ex_aluin1_m,
  output logic             ex_aluin2_m,
  output logic             ex_aluPC_m,
  output logic             ex_aluImm_m,
  output logic             ex_memRead,
  output logic             ex_memWrite,
  output logic             ex_regWrite,
  output logic             ex_branch,
  output logic [2:0]       ex_funct3
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic             ex_illegal
`endif
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e           r_state, w_state_next;
  id_ex_t           r_idex, w_idex_next, w_dec;
  logic             w_dec_ok;
  logic             w_advance, w_hazard;
  logic [DataW-1:0] w_imm;
  opcode_t          w_opcode;
  logic [6:0]       w_f7;
  logic [2:0]       w_f3;

  assign w_opcode = opcode_t'(if_instr[6:0]);
  assign w_f7     = if_instr[31:25];
  assign w_f3     = if_instr[14:12];

  imm_gen u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  // Decoder table: instruction word -> control bundle plus legality flag.
  always_comb begin
    w_dec           = '0;
    w_dec.valid     = 1'b1;
    w_dec.pc        = if_pc;
    w_dec.imm       = w_imm;
    w_dec.funct3    = w_f3;
    w_dec.alu_code  = AluNop;
    w_dec.alu_pc_m  = 1'b1;
    w_dec.alu_imm_m = 1'b1;
    w_dec_ok        = 1'b0;
    case (w_opcode)
      OpOp: begin
        w_dec.rs1       = if_instr[19:15];
        w_dec.rs2       = if_instr[24:20];
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.alu_code  = alu_op(w_f3, if_instr[30]);
        w_dec_ok        = (w_f7 == 7'b0000000) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OpImm: begin
        w_dec.rs1       = if_instr[19:15];
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.aluin2_m  = 1'b1;
        // Only the shift-right form uses instr[30] (SRAI); ADDI never subtracts.
        w_dec.alu_code  = alu_op(w_f3, (w_f3 == 3'b101) && if_instr[30]);
        if (w_f3 == 3'b001)      w_dec_ok = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101) w_dec_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        else                     w_dec_ok = 1'b1;
      end
      OpLui: begin
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.alu_code  = AluAdd;
        w_dec.aluin2_m  = 1'b1;
        w_dec.alu_imm_m = 1'b0;
        w_dec_ok        = 1'b1;
      end
      OpAuipc: begin
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.alu_code  = AluAdd;
        w_dec.aluin1_m  = 1'b1;
        w_dec.aluin2_m  = 1'b1;
        w_dec_ok        = 1'b1;
      end
      OpJal: begin
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.alu_code  = AluAdd;
        w_dec.aluin1_m  = 1'b1;
        w_dec.aluin2_m  = 1'b1;
        w_dec.alu_pc_m  = 1'b0;
        w_dec_ok        = 1'b1;
      end
      OpJalr: begin
        w_dec.rs1       = if_instr[19:15];
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.alu_code  = AluAdd;
        w_dec.aluin2_m  = 1'b1;
        w_dec.alu_pc_m  = 1'b0;
        w_dec_ok        = (w_f3 == 3'b000);
      end
      OpBranch: begin
        w_dec.rs1       = if_instr[19:15];
        w_dec.rs2       = if_instr[24:20];
        w_dec.alu_code  = AluSub;
        w_dec.branch    = 1'b1;
        w_dec_ok        = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      OpLoad: begin
        w_dec.rs1       = if_instr[19:15];
        w_dec.rd        = if_instr[11:7];
        w_dec.reg_write = 1'b1;
        w_dec.mem_read  = 1'b1;
        w_dec.alu_code  = AluAdd;
        w_dec.aluin2_m  = 1'b1;
        w_dec_ok        = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      end
      OpStore: begin
        w_dec.rs1       = if_instr[19:15];
        w_dec.rs2       = if_instr[24:20];
        w_dec.mem_write = 1'b1;
        w_dec.alu_code  = AluAdd;
        w_dec.aluin2_m  = 1'b1;
        w_dec_ok        = (w_f3 <= 3'b010);
      end
      default: w_dec_ok = 1'b0;
    endcase
    // Writes to x0 are architecturally discarded.
    if (w_dec.rd == '0) w_dec.reg_write = 1'b0;
  end

  // Load-use interlock; unused rs fields are already 0 and ex_rd!=0 is required.
  always_comb begin
    w_advance = !r_idex.valid || ex_ready;
    w_hazard  = r_idex.valid && r_idex.mem_read && (r_idex.rd != '0) &&
                ((w_dec.rs1 == r_idex.rd) || (w_dec.rs2 == r_idex.rd));
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal, w_illegal_next;
`endif

  // Next-state for FSM and ID/EX register, plus the fetch-side ready.
  always_comb begin
    w_state_next = r_state;
    w_idex_next  = r_idex;
`ifdef DECODE_ILLEGAL_TRAP_EN
    w_illegal_next = r_illegal;
`endif
    if (r_state == StRun) begin
      if (flush) begin
        w_idex_next = bubble_bundle(RESET_PC);
      end else if (w_advance) begin
        if (w_hazard || !if_valid) begin
          w_idex_next = bubble_bundle(RESET_PC);
        end else if (w_dec_ok) begin
          w_idex_next = w_dec;
        end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
          w_idex_next       = bubble_bundle(if_pc);
          w_idex_next.valid = 1'b1;
          w_illegal_next    = 1'b1;
          w_state_next      = StHalt;
`else
          w_idex_next = bubble_bundle(RESET_PC);
`endif
        end
      end
    end
    if_ready = nRst && (r_state == StRun) && (flush || (w_advance && !w_hazard));
  end

  // State and ID/EX register; reset clears everything immediately.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= StRun;
      r_idex  <= bubble_bundle(RESET_PC);
    end else begin
      r_state <= w_state_next;
      r_idex  <= w_idex_next;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_illegal <= 1'b0;
    else       r_illegal <= w_illegal_next;
  end
  assign ex_illegal = r_illegal;
`endif

  assign ex_valid    = r_idex.valid;
  assign ex_pc       = r_idex.pc;
  assign ex_rs1      = r_idex.rs1;
  assign ex_rs2      = r_idex.rs2;
  assign ex_rd       = r_idex.rd;
  assign ex_imm      = r_idex.imm;
  assign ex_aluCode  = r_idex.alu_code;
  assign ex_aluin1_m = r_idex.aluin1_m;
  assign ex_aluin2_m = r_idex.aluin2_m;
  assign ex_aluPC_m  = r_idex.alu_pc_m;
  assign ex_aluImm_m = r_idex.alu_imm_m;
  assign ex_memRead  = r_idex.mem_read;
  assign ex_memWrite = r_idex.mem_write;
  assign ex_regWrite = r_idex.reg_write;
  assign ex_branch   = r_idex.branch;
  assign ex_funct3   = r_idex.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-encoded RV32I words, expected
// control bundles computed by hand. Illegal-trap checks follow the
// DECODE_ILLEGAL_TRAP_EN macro.
module tb_decode_stage;
  import coreUtils::*;

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'h0;
  logic [31:0] if_pc = 32'h0;
  logic        if_ready;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  alu_codes_t  ex_aluCode;
  logic        ex_aluin1_m, ex_aluin2_m, ex_aluPC_m, ex_aluImm_m;
  logic        ex_memRead, ex_memWrite, ex_regWrite, ex_branch;
  logic [2:0]  ex_funct3;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_imm      (ex_imm),
    .ex_aluCode  (ex_aluCode),
    .ex_aluin1_m (ex_aluin1_m),
    .ex_aluin2_m (ex_aluin2_m),
    .ex_aluPC_m  (ex_aluPC_m),
    .ex_aluImm_m (ex_aluImm_m),
    .ex_memRead  (ex_memRead),
    .ex_memWrite (ex_memWrite),
    .ex_regWrite (ex_regWrite),
    .ex_branch   (ex_branch),
    .ex_funct3   (ex_funct3)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .ex_illegal  (ex_illegal)
`endif
  );

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic test_reset();
    #2 nRst = 1'b0;
    #1;
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b exp 0", ex_valid); end
    n_tests++; if (ex_aluCode !== AluNop) begin n_fail++; $display("FAIL rst_alucode: got %0d exp %0d", ex_aluCode, AluNop); end
    n_tests++; if (ex_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", ex_pc); end
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready: got %0b exp 0", if_ready); end
    n_tests++; if ({ex_regWrite, ex_memRead, ex_memWrite, ex_branch, ex_aluImm_m, ex_aluPC_m} !== 6'b0)
      begin n_fail++; $display("FAIL rst_ctrl: got %b exp 000000", {ex_regWrite, ex_memRead, ex_memWrite, ex_branch, ex_aluImm_m, ex_aluPC_m}); end
    tick();
    tick();
    nRst = 1'b1;
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b exp 1", if_ready); end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h00510093, 32'h100);
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL addi_if_ready: got %0b exp 1", if_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b exp 1", ex_valid); end
    n_tests++; if (ex_aluCode !== AluAdd) begin n_fail++; $display("FAIL addi_alucode: got %0d exp %0d", ex_aluCode, AluAdd); end
    n_tests++; if (ex_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h exp 5", ex_imm); end
    n_tests++; if ({ex_rs1, ex_rs2, ex_rd} !== {5'd2, 5'd0, 5'd1})
      begin n_fail++; $display("FAIL addi_regs: got %0d/%0d/%0d exp 2/0/1", ex_rs1, ex_rs2, ex_rd); end
    n_tests++; if ({ex_aluin1_m, ex_aluin2_m, ex_aluPC_m, ex_aluImm_m, ex_regWrite, ex_memRead, ex_memWrite, ex_branch} !== 8'b01111000)
      begin n_fail++; $display("FAIL addi_ctrl: got %b exp 01111000", {ex_aluin1_m, ex_aluin2_m, ex_aluPC_m, ex_aluImm_m, ex_regWrite, ex_memRead, ex_memWrite, ex_branch}); end
    n_tests++; if (ex_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %h exp 100", ex_pc); end
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0b exp 0", ex_valid); end
  endtask

  // LUI, JAL, BEQ, ADDI x0 issued on consecutive cycles.
  task automatic test_back_to_back();
    drive(1'b1, 32'h123452B7, 32'h200);
    tick();
    drive(1'b1, 32'h008000EF, 32'h204);
    n_tests++; if (ex_aluImm_m !== 1'b0) begin n_fail++; $display("FAIL lui_aluimm: got %0b exp 0", ex_aluImm_m); end
    n_tests++; if (ex_imm !== 32'h12345000) begin n_fail++; $display("FAIL lui_imm: got %h exp 12345000", ex_imm); end
    n_tests++; if ({ex_rd, ex_rs1, ex_regWrite} !== {5'd5, 5'd0, 1'b1})
      begin n_fail++; $display("FAIL lui_regs: got rd=%0d rs1=%0d rw=%0b exp 5/0/1", ex_rd, ex_rs1, ex_regWrite); end
    tick();
    drive(1'b1, 32'h00208463, 32'h208);
    n_tests++; if ({ex_aluin1_m, ex_aluin2_m, ex_aluPC_m, ex_aluImm_m} !== 4'b1101)
      begin n_fail++; $display("FAIL jal_mux: got %b exp 1101", {ex_aluin1_m, ex_aluin2_m, ex_aluPC_m, ex_aluImm_m}); end
    n_tests++; if ({ex_imm, ex_rd, ex_aluCode} !== {32'd8, 5'd1, AluAdd})
      begin n_fail++; $display("FAIL jal_fields: got imm=%h rd=%0d code=%0d exp 8/1/%0d", ex_imm, ex_rd, ex_aluCode, AluAdd); end
    tick();
    drive(1'b1, 32'h00000013, 32'h20C);
    n_tests++; if ({ex_aluCode, ex_branch, ex_regWrite, ex_imm} !== {AluSub, 1'b1, 1'b0, 32'd8})
      begin n_fail++; $display("FAIL beq_fields: got code=%0d br=%0b rw=%0b imm=%h exp %0d/1/0/8", ex_aluCode, ex_branch, ex_regWrite, ex_imm, AluSub); end
    n_tests++; if ({ex_rs1, ex_rs2} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL beq_regs: got %0d/%0d exp 1/2", ex_rs1, ex_rs2); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if ({ex_valid, ex_regWrite} !== 2'b10)
      begin n_fail++; $display("FAIL x0_regwrite: got v=%0b rw=%0b exp 1/0", ex_valid, ex_regWrite); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h0000A183, 32'h300);
    tick();
    n_tests++; if ({ex_valid, ex_memRead, ex_rd, ex_funct3} !== {1'b1, 1'b1, 5'd3, 3'b010})
      begin n_fail++; $display("FAIL lw_fields: got v=%0b mr=%0b rd=%0d f3=%0d exp 1/1/3/2", ex_valid, ex_memRead, ex_rd, ex_funct3); end
    drive(1'b1, 32'h00218233, 32'h304);
    #1;
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall_ready: got %0b exp 0", if_ready); end
    tick();
    n_tests++; if ({ex_valid, ex_aluCode} !== {1'b0, AluNop})
      begin n_fail++; $display("FAIL lu_bubble: got v=%0b code=%0d exp 0/%0d", ex_valid, ex_aluCode, AluNop); end
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL lu_resume_ready: got %0b exp 1", if_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if ({ex_valid, ex_aluCode, ex_rd, ex_rs1, ex_rs2, ex_pc} !== {1'b1, AluAdd, 5'd4, 5'd3, 5'd2, 32'h304})
      begin n_fail++; $display("FAIL lu_add: got v=%0b code=%0d rd=%0d rs=%0d/%0d pc=%h exp 1/0/4/3/2/304", ex_valid, ex_aluCode, ex_rd, ex_rs1, ex_rs2, ex_pc); end
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h407302B3, 32'h400);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, 32'h00510093, 32'h404);
    n_tests++; if ({ex_valid, ex_aluCode} !== {1'b1, AluSub})
      begin n_fail++; $display("FAIL sub_load: got v=%0b code=%0d exp 1/%0d", ex_valid, ex_aluCode, AluSub); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %0b exp 0", i, if_ready); end
      tick();
      n_tests++; if ({ex_valid, ex_aluCode, ex_rd, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_regWrite, ex_aluin2_m} !==
                     {1'b1, AluSub, 5'd5, 5'd6, 5'd7, 32'h400, 32'h0, 1'b1, 1'b0})
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b code=%0d rd=%0d rs=%0d/%0d pc=%h exp 1/%0d/5/6/7/400", i, ex_valid, ex_aluCode, ex_rd, ex_rs1, ex_rs2, ex_pc, AluSub); end
    end
    ex_ready = 1'b1;
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %0b exp 1", if_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if ({ex_valid, ex_aluCode, ex_rd, ex_pc} !== {1'b1, AluAdd, 5'd1, 32'h404})
      begin n_fail++; $display("FAIL stall_next: got v=%0b code=%0d rd=%0d pc=%h exp 1/0/1/404", ex_valid, ex_aluCode, ex_rd, ex_pc); end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0000A183, 32'h500);
    tick();
    drive(1'b1, 32'h00218233, 32'h504);
    #1;
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_stall: got %0b exp 0", if_ready); end
    flush = 1'b1;
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b exp 1", if_ready); end
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h00510093, 32'h600);
    n_tests++; if ({ex_valid, ex_aluCode, ex_pc} !== {1'b0, AluNop, 32'h0})
      begin n_fail++; $display("FAIL flush_bubble: got v=%0b code=%0d pc=%h exp 0/%0d/0", ex_valid, ex_aluCode, ex_pc, AluNop); end
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready: got %0b exp 1", if_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd1, 32'h600})
      begin n_fail++; $display("FAIL flush_target: got v=%0b rd=%0d pc=%h exp 1/1/600", ex_valid, ex_rd, ex_pc); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00510093, 32'h700);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #2 nRst = 1'b0;
    #1;
    n_tests++; if ({ex_valid, ex_rd, ex_imm, ex_regWrite, ex_aluCode} !== {1'b0, 5'd0, 32'd0, 1'b0, AluNop})
      begin n_fail++; $display("FAIL async_rst: got v=%0b rd=%0d imm=%h rw=%0b code=%0d exp cleared", ex_valid, ex_rd, ex_imm, ex_regWrite, ex_aluCode); end
    tick();
    nRst = 1'b1;
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hFFFFFFFF, 32'h800);
    tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
    drive(1'b1, 32'h00510093, 32'h804);
    n_tests++; if ({ex_illegal, ex_valid, ex_aluCode} !== {1'b1, 1'b1, AluNop})
      begin n_fail++; $display("FAIL illegal_capture: got ill=%0b v=%0b code=%0d exp 1/1/%0d", ex_illegal, ex_valid, ex_aluCode, AluNop); end
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready[%0d]: got %0b exp 0", i, if_ready); end
      tick();
    end
    flush = 1'b0;
    n_tests++; if (ex_illegal !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %0b exp 1", ex_illegal); end
    nRst = 1'b0;
    #1;
    n_tests++; if ({ex_illegal, ex_valid} !== 2'b00) begin n_fail++; $display("FAIL halt_reset: got %b exp 00", {ex_illegal, ex_valid}); end
    tick();
    nRst = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if ({ex_valid, ex_rd} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL halt_resume: got v=%0b rd=%0d exp 1/1", ex_valid, ex_rd); end
`else
    drive(1'b1, 32'h00510093, 32'h804);
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_bubble: got %0b exp 0", ex_valid); end
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %0b exp 1", if_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_tests++; if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd1, 32'h804})
      begin n_fail++; $display("FAIL illegal_continue: got v=%0b rd=%0d pc=%h exp 1/1/804", ex_valid, ex_rd, ex_pc); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_stall();
    test_flush();
    test_async_reset();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
